regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the multi-cycle core's 32-entry register file. It shares the register file's single write port between two write-back requesters, the ALU and the load unit, using valid/ready handshakes. It drives a registered write (`rf_we`/`rf_waddr`/`rf_wdata`) one cycle after acceptance. It keeps a pending-write scoreboard that the decode stage queries to stall on read-after-write hazards.

## Interface
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register index width (32 registers).

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `alu_valid`  in  1  ALU write-back request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_rd`  in  ADDR_W  ALU destination
- `alu_data`  in  DATA_W  ALU result
- `mem_valid`  in  1  load write-back request
- `mem_ready`  out  1  load request accepted this cycle
- `mem_rd`  in  ADDR_W  load destination
- `mem_data`  in  DATA_W  load data
- `issue_valid`  in  1  decode issues an instruction with a destination
- `issue_rd`  in  ADDR_W  destination being issued
- `flush`  in  1  clear scoreboard (pipeline flush)
- `chk_rs1`, `chk_rs2`  in  ADDR_W each  sources to hazard-check
- `hazard`  out  1  rs1 or rs2 has a pending write
- `rf_we`  out  1  register file write enable
- `rf_waddr`  out  ADDR_W  write index
- `rf_wdata`  out  DATA_W  write data
- `pending`  out  32  scoreboard bit vector

## Operation
- Arbitration is combinational:
  - Only one valid: that requester gets ready=1.
  - Both valid: the winner comes from the policy in Configuration; the loser's ready=0 and it must hold valid/rd/data stable until accepted.
- Acceptance is `valid & ready` at a rising edge. At most one acceptance per cycle. ready is never asserted without valid.
- Accepted with rd≠0: register `rf_we`=1, `rf_waddr`=rd and `rf_wdata`=data for exactly the next cycle. Otherwise `rf_we`=0; `rf_waddr`/`rf_wdata` hold their last value.
- Accepted with rd=0: the request is consumed (ready=1) but no write is issued. r0 is never written.
- Scoreboard, `pending[i]`:
  - Set on `issue_valid` with `issue_rd`=i≠0.
  - Cleared at the edge where a write-back to i is accepted.
  - Set and clear of the same index in the same cycle: set wins.
  - `pending[0]` is constant 0.
  - `flush` clears all bits. A simultaneous issue is ignored.
- `hazard` = `pending[chk_rs1] | pending[chk_rs2]`, combinational from current state. Index 0 never hazards.
- Reset: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `pending`=0, round-robin pointer=ALU-preferred. Both readies are 0 during reset.

## Timing
- Request to register file write: 1 cycle (accept at edge N, `rf_we` high during cycle N+1, data lands at edge N+1).
- ready depends combinationally on valid and the pointer only. There is no path from `rf_*` back to ready.
- Back-to-back acceptances every cycle are allowed; `rf_we` may stay high continuously.
- `hazard` for a register whose write-back is accepted at edge N drops after edge N. Decode may read the register file after edge N+1.
- Reset asserted mid-transfer: the in-flight registered write is dropped (`rf_we`=0 next cycle) and `pending` is cleared.

## Configuration
- `RF_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin between the two requesters.
  - A 1-bit pointer flips to favour the other requester after every acceptance made while both were valid.
  - Uncontended acceptances leave the pointer unchanged.
- Not defined: fixed priority, load unit over ALU. There is no pointer, and the ALU can starve while `mem_valid` is held.

## Test plan
- After reset, `alu_valid`=1, rd=3, data=0x00000007 → `alu_ready`=1. Next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x7. The cycle after, `rf_we`=0.
- Both valid for 4 cycles (alu rd=1, mem rd=2):
  - With `RF_ARB_ROUND_ROBIN_EN`: grants ALU, MEM, ALU, MEM.
  - Without it: MEM ×4 and `alu_ready`=0 throughout.
- `issue_valid` rd=5, then `chk_rs1`=5 → `hazard`=1. Accept mem rd=5 → `hazard`=0 the following cycle and `pending[5]`=0.
- Same cycle: `issue_valid` rd=4 and ALU write-back rd=4 accepted → `pending[4]`=1 afterwards and `rf_we` still issues a write to r4.
- ALU write-back with rd=0, data=0xFFFFFFFF → `alu_ready`=1, `rf_we` stays 0. `issue_valid` rd=0 leaves `pending`=0.
- Set pending bits 1, 7 and 31, then pulse `flush` with `issue_valid` rd=9 → `pending`=0. Assert reset while a write is registered → `rf_we`=0 the next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load write-back and tracks pending writes.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the load unit has fixed priority.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_rs1,
    input  logic [ADDR_W-1:0] chk_rs2,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pending
);
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]       pending_q, pending_d;
    logic              acc;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic [31:0]       set_mask, clr_mask;

`ifdef RF_ARB_ROUND_ROBIN_EN
    // ptr_q=0 favours the ALU; flips only on contended acceptances
    logic ptr_q, ptr_d;

    always_comb begin
        alu_ready = ~reset & alu_valid & (~mem_valid | ~ptr_q);
        mem_ready = ~reset & mem_valid & (~alu_valid | ptr_q);
        ptr_d     = (alu_valid & mem_valid) ? ~ptr_q : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        mem_ready = ~reset & mem_valid;
        alu_ready = ~reset & alu_valid & ~mem_valid;
    end
`endif

    always_comb begin
        acc        = alu_ready | mem_ready;
        acc_rd     = mem_ready ? mem_rd : alu_rd;
        acc_data   = mem_ready ? mem_data : alu_data;
        rf_we_d    = acc & (acc_rd != '0);
        rf_waddr_d = rf_we_d ? acc_rd : rf_waddr_q;
        rf_wdata_d = rf_we_d ? acc_data : rf_wdata_q;
        set_mask   = issue_valid ? (32'd1 << issue_rd) : 32'd0;
        clr_mask   = acc ? (32'd1 << acc_rd) : 32'd0;
        // set is OR'd after clear so a same-cycle issue wins
        pending_d  = flush ? 32'd0 : (((pending_q & ~clr_mask) | set_mask) & ~32'd1);
        hazard     = pending_q[chk_rs1] | pending_q[chk_rs2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;
endmodule
